window_addr_gen: RTL and testbench

Address sequencer for the 3x3 convolution stage. On a start pulse it walks a feature map of run-time width and height stored row-major in the on-chip feature memory. It emits, over a valid/ready stream, the nine read addresses of every 3x3 window (stride 1, no padding). It sits between the layer controller and the feature-memory read port, and its output feeds the MAC array's operand fetch.

---
 rtl/window_addr_gen.sv | 185 ++++++++++++++++++
 tb/tb_window_addr_gen.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_addr_gen.sv
// window_addr_gen
//   Address sequencer for the 3x3 convolution stage. After a Start pulse it
//   walks a row-major feature map of run-time size W x H. For every 3x3 window
//   (stride 1, no padding) it emits the nine read addresses over a valid/ready
//   stream. Windows come in raster order: output column fastest, then output
//   row. Elements within a window come kx fastest, then ky.
//
//   Handshake: an address transfers on a rising edge where Valid=1 and
//   Ready=1. While Valid=1 and Ready=0, Addr, Win_Last and Valid hold.
//   Ready is ignored while Valid=0.
//
// Ports
//   WINDOW_ADDR_GEN_Clk        clock, rising edge
//   WINDOW_ADDR_GEN_Clr        synchronous active-high reset
//   WINDOW_ADDR_GEN_Start      start pulse, only honoured in IDLE
//   WINDOW_ADDR_GEN_Img_W/H    image width / height, latched on Start
//   WINDOW_ADDR_GEN_Base       address of pixel (0,0), latched on Start
//   WINDOW_ADDR_GEN_Ready      downstream accepts current address
//   WINDOW_ADDR_GEN_Addr       registered read address
//   WINDOW_ADDR_GEN_Valid      Addr is valid
//   WINDOW_ADDR_GEN_Win_Last   Addr is the 9th element of its window
//   WINDOW_ADDR_GEN_Busy       high while in RUN
//   WINDOW_ADDR_GEN_Done       one-cycle pulse at end of frame
//   WINDOW_ADDR_GEN_Dbg_State  current FSM state (0 IDLE, 1 RUN, 2 DONE)
module window_addr_gen #(
   parameter int ADDR_W = 10,
   parameter int DIM_W  = 5
) (
   input  logic              WINDOW_ADDR_GEN_Clk,
   input  logic              WINDOW_ADDR_GEN_Clr,
   input  logic              WINDOW_ADDR_GEN_Start,
   input  logic [DIM_W-1:0]  WINDOW_ADDR_GEN_Img_W,
   input  logic [DIM_W-1:0]  WINDOW_ADDR_GEN_Img_H,
   input  logic [ADDR_W-1:0] WINDOW_ADDR_GEN_Base,
   input  logic              WINDOW_ADDR_GEN_Ready,
   output logic [ADDR_W-1:0] WINDOW_ADDR_GEN_Addr,
   output logic              WINDOW_ADDR_GEN_Valid,
   output logic              WINDOW_ADDR_GEN_Win_Last,
   output logic              WINDOW_ADDR_GEN_Busy,
   output logic              WINDOW_ADDR_GEN_Done,
   output logic [1:0]        WINDOW_ADDR_GEN_Dbg_State
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state;
   logic [DIM_W-1:0]  w_r;
   logic [DIM_W-1:0]  h_r;
   logic [DIM_W-1:0]  ox;
   logic [DIM_W-1:0]  oy;
   logic [1:0]        kx;
   logic [1:0]        ky;
   logic [ADDR_W-1:0] win_base;
   logic [ADDR_W-1:0] row_ptr;
   logic [ADDR_W-1:0] addr_r;
   logic              valid_r;
   logic              last_r;
   logic              busy_r;
   logic              done_r;

   logic [ADDR_W-1:0] w_ext;
   logic              handshake;
   logic              row_end;
   logic              frame_end;
   logic [ADDR_W-1:0] next_win_base;
   logic              dims_ok;

   // The size cast zero-extends W (or truncates it when DIM_W > ADDR_W).
   // Address arithmetic wraps modulo 2^ADDR_W.
   assign w_ext     = ADDR_W'(w_r);
   assign handshake = valid_r & WINDOW_ADDR_GEN_Ready;
   // W and H are at least 3 in RUN, so these subtractions cannot underflow.
   assign row_end   = (ox == (w_r - DIM_W'(3)));
   assign frame_end = row_end && (oy == (h_r - DIM_W'(3)));
   // At the end of a window, step one column to the right. At the end of an
   // output row, skip the two right-edge columns and land on the first pixel
   // of the next row: (W-3) single steps + 3 = W.
   assign next_win_base = win_base + (row_end ? ADDR_W'(3) : ADDR_W'(1));
   assign dims_ok   = (WINDOW_ADDR_GEN_Img_W >= DIM_W'(3)) &&
                      (WINDOW_ADDR_GEN_Img_H >= DIM_W'(3));

   always_ff @(posedge WINDOW_ADDR_GEN_Clk) begin
      if (WINDOW_ADDR_GEN_Clr) begin
         state    <= ST_IDLE;
         w_r      <= '0;
         h_r      <= '0;
         ox       <= '0;
         oy       <= '0;
         kx       <= '0;
         ky       <= '0;
         win_base <= '0;
         row_ptr  <= '0;
         addr_r   <= '0;
         valid_r  <= 1'b0;
         last_r   <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (WINDOW_ADDR_GEN_Start) begin
                  w_r      <= WINDOW_ADDR_GEN_Img_W;
                  h_r      <= WINDOW_ADDR_GEN_Img_H;
                  win_base <= WINDOW_ADDR_GEN_Base;
                  row_ptr  <= WINDOW_ADDR_GEN_Base;
                  addr_r   <= WINDOW_ADDR_GEN_Base;
                  ox       <= '0;
                  oy       <= '0;
                  kx       <= '0;
                  ky       <= '0;
                  last_r   <= 1'b0;
                  if (dims_ok) begin
                     state   <= ST_RUN;
                     valid_r <= 1'b1;
                     busy_r  <= 1'b1;
                  end else begin
                     // A map smaller than 3x3 has no windows. Finish at once.
                     state  <= ST_DONE;
                     done_r <= 1'b1;
                  end
               end
            end

            ST_RUN: begin
               if (handshake) begin
                  if (kx != 2'd2) begin
                     // Next pixel in the same window row.
                     kx     <= kx + 2'd1;
                     addr_r <= addr_r + ADDR_W'(1);
                     last_r <= (kx == 2'd1) && (ky == 2'd2);
                  end else if (ky != 2'd2) begin
                     // Next window row: move down one image row.
                     kx      <= 2'd0;
                     ky      <= ky + 2'd1;
                     row_ptr <= row_ptr + w_ext;
                     addr_r  <= row_ptr + w_ext;
                     last_r  <= 1'b0;
                  end else if (frame_end) begin
                     state   <= ST_DONE;
                     valid_r <= 1'b0;
                     busy_r  <= 1'b0;
                     last_r  <= 1'b0;
                     done_r  <= 1'b1;
                  end else begin
                     // Next window.
                     kx       <= 2'd0;
                     ky       <= 2'd0;
                     last_r   <= 1'b0;
                     win_base <= next_win_base;
                     row_ptr  <= next_win_base;
                     addr_r   <= next_win_base;
                     if (row_end) begin
                        ox <= '0;
                        oy <= oy + DIM_W'(1);
                     end else begin
                        ox <= ox + DIM_W'(1);
                     end
                  end
               end
            end

            ST_DONE: begin
               done_r <= 1'b0;
               state  <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign WINDOW_ADDR_GEN_Addr      = addr_r;
   assign WINDOW_ADDR_GEN_Valid     = valid_r;
   assign WINDOW_ADDR_GEN_Win_Last  = last_r;
   assign WINDOW_ADDR_GEN_Busy      = busy_r;
   assign WINDOW_ADDR_GEN_Done      = done_r;
   assign WINDOW_ADDR_GEN_Dbg_State = state;

endmodule

// File: tb/tb_window_addr_gen.sv
// tb_window_addr_gen
//   Directed bench for window_addr_gen. A 10-bit instance runs the frame,
//   degenerate, backpressure, abort and ignored-start cases. A 4-bit address
//   instance checks the modulo-16 address wrap.
module tb_window_addr_gen;

   localparam int AW = 10;
   localparam int DW = 5;
   localparam int SAW = 4;

   // ---------------- clock / reset ----------------
   logic clk;
   logic clr;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // main instance
   logic          start;
   logic [DW-1:0] img_w;
   logic [DW-1:0] img_h;
   logic [AW-1:0] base;
   logic          ready;
   logic [AW-1:0] addr;
   logic          valid;
   logic          win_last;
   logic          busy;
   logic          done;
   logic [1:0]    dbg_state;

   // small-address instance
   logic           s_start;
   logic [DW-1:0]  s_img_w;
   logic [DW-1:0]  s_img_h;
   logic [SAW-1:0] s_base;
   logic           s_ready;
   logic [SAW-1:0] s_addr;
   logic           s_valid;
   logic           s_win_last;
   logic           s_busy;
   logic           s_done;
   logic [1:0]     s_dbg_state;

   window_addr_gen #(.ADDR_W(AW), .DIM_W(DW)) u_dut (
      .WINDOW_ADDR_GEN_Clk       (clk),
      .WINDOW_ADDR_GEN_Clr       (clr),
      .WINDOW_ADDR_GEN_Start     (start),
      .WINDOW_ADDR_GEN_Img_W     (img_w),
      .WINDOW_ADDR_GEN_Img_H     (img_h),
      .WINDOW_ADDR_GEN_Base      (base),
      .WINDOW_ADDR_GEN_Ready     (ready),
      .WINDOW_ADDR_GEN_Addr      (addr),
      .WINDOW_ADDR_GEN_Valid     (valid),
      .WINDOW_ADDR_GEN_Win_Last  (win_last),
      .WINDOW_ADDR_GEN_Busy      (busy),
      .WINDOW_ADDR_GEN_Done      (done),
      .WINDOW_ADDR_GEN_Dbg_State (dbg_state)
   );

   window_addr_gen #(.ADDR_W(SAW), .DIM_W(DW)) u_small (
      .WINDOW_ADDR_GEN_Clk       (clk),
      .WINDOW_ADDR_GEN_Clr       (clr),
      .WINDOW_ADDR_GEN_Start     (s_start),
      .WINDOW_ADDR_GEN_Img_W     (s_img_w),
      .WINDOW_ADDR_GEN_Img_H     (s_img_h),
      .WINDOW_ADDR_GEN_Base      (s_base),
      .WINDOW_ADDR_GEN_Ready     (s_ready),
      .WINDOW_ADDR_GEN_Addr      (s_addr),
      .WINDOW_ADDR_GEN_Valid     (s_valid),
      .WINDOW_ADDR_GEN_Win_Last  (s_win_last),
      .WINDOW_ADDR_GEN_Busy      (s_busy),
      .WINDOW_ADDR_GEN_Done      (s_done),
      .WINDOW_ADDR_GEN_Dbg_State (s_dbg_state)
   );

   // ---------------- scoreboard ----------------
   logic [AW-1:0] exp_q[$];
   int err_cnt = 0;
   int chk_cnt = 0;

   int tbl_4x4 [36] = '{0, 1, 2, 4, 5, 6, 8, 9, 10,
                        1, 2, 3, 5, 6, 7, 9, 10, 11,
                        4, 5, 6, 8, 9, 10, 12, 13, 14,
                        5, 6, 7, 9, 10, 11, 13, 14, 15};
   int tbl_wrap [9] = '{14, 15, 0, 1, 2, 3, 4, 5, 6};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: direct formula with a multiplier.
   task automatic fill_model(input int w, input int h, input int b);
      for (int oy = 0; oy <= h - 3; oy++)
         for (int ox = 0; ox <= w - 3; ox++)
            for (int ky = 0; ky < 3; ky++)
               for (int kx = 0; kx < 3; kx++)
                  exp_q.push_back(AW'(b + (oy + ky) * w + ox + kx));
   endtask

   task automatic fill_4x4();
      for (int i = 0; i < 36; i++) exp_q.push_back(AW'(tbl_4x4[i]));
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      @(negedge clk);
      clr = 1'b0;
   endtask

   // Runs one frame on the main instance against exp_q.
   //   pat         : ready pattern, bit (cycle % 4)
   //   abort_after : nonzero -> assert Clr after that many handshakes
   //   poke        : pulse Start mid-run and in the DONE cycle
   task automatic run_frame(input int w, input int h, input int b,
                            input logic [3:0] pat, input int abort_after,
                            input bit poke, input string name);
      int cyc;
      int hs;
      bit hold;
      logic [AW-1:0] held;
      cyc  = 0;
      hs   = 0;
      hold = 1'b0;
      held = '0;
      @(negedge clk);
      img_w = DW'(w);
      img_h = DW'(h);
      base  = AW'(b);
      start = 1'b1;
      while (exp_q.size() > 0 && cyc < 400) begin
         @(negedge clk);
         start = 1'b0;
         ready = pat[cyc % 4];
         if (poke && cyc == 5) begin
            start = 1'b1;
            img_w = DW'(9);
            img_h = DW'(9);
            base  = AW'(500);
         end
         if (hold) check({name, "_hold_addr"}, 32'(addr), 32'(held));
         check({name, "_valid"}, 32'(valid), 1);
         check({name, "_busy"}, 32'(busy), 1);
         check({name, "_done_low"}, 32'(done), 0);
         if (valid) begin
            check({name, "_addr"}, 32'(addr), 32'(exp_q[0]));
            check({name, "_win_last"}, 32'(win_last), 32'((hs % 9) == 8));
            if (ready) begin
               void'(exp_q.pop_front());
               hs++;
               hold = 1'b0;
            end else begin
               hold = 1'b1;
               held = addr;
            end
         end
         cyc++;
         if (abort_after != 0 && hs == abort_after) break;
      end

      if (abort_after != 0) begin
         exp_q.delete();
         @(negedge clk);
         clr = 1'b1;
         @(negedge clk);
         clr = 1'b0;
         check({name, "_clr_addr"}, 32'(addr), 0);
         check({name, "_clr_valid"}, 32'(valid), 0);
         check({name, "_clr_last"}, 32'(win_last), 0);
         check({name, "_clr_busy"}, 32'(busy), 0);
         check({name, "_clr_done"}, 32'(done), 0);
         check({name, "_clr_state"}, 32'(dbg_state), 0);
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check({name, "_clr_no_done"}, 32'(done), 0);
         end
      end else begin
         if (exp_q.size() != 0) begin
            check({name, "_timeout_left"}, 32'(exp_q.size()), 0);
            exp_q.delete();
         end
         @(negedge clk);
         if (poke) start = 1'b1;
         check({name, "_end_done"}, 32'(done), 1);
         check({name, "_end_valid"}, 32'(valid), 0);
         check({name, "_end_busy"}, 32'(busy), 0);
         @(negedge clk);
         start = 1'b0;
         check({name, "_post_done"}, 32'(done), 0);
         check({name, "_post_state"}, 32'(dbg_state), 0);
         @(negedge clk);
         check({name, "_post_valid"}, 32'(valid), 0);
         check({name, "_post_busy"}, 32'(busy), 0);
         check({name, "_post_done2"}, 32'(done), 0);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      clr     = 1'b0;
      start   = 1'b0;
      img_w   = '0;
      img_h   = '0;
      base    = '0;
      ready   = 1'b0;
      s_start = 1'b0;
      s_img_w = '0;
      s_img_h = '0;
      s_base  = '0;
      s_ready = 1'b0;

      // Reset state
      do_reset();
      check("rst_addr", 32'(addr), 0);
      check("rst_valid", 32'(valid), 0);
      check("rst_last", 32'(win_last), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_state", 32'(dbg_state), 0);
      check("rst_s_addr", 32'(s_addr), 0);
      check("rst_s_valid", 32'(s_valid), 0);

      // 4x4, base 0, Ready tied high, hand table
      fill_4x4();
      run_frame(4, 4, 0, 4'b1111, 0, 1'b0, "f4x4");

      // 5x3, base 100, Ready 1,0,0,1 repeating
      check("f5x3_hand_first", 32'(AW'(100 + 5 + 0)), 32'(105)); // sanity of the model formula at (ky=1)
      fill_model(5, 3, 100);
      check("f5x3_q_len", 32'(exp_q.size()), 27);
      check("f5x3_q3", 32'(exp_q[3]), 105);
      check("f5x3_q8", 32'(exp_q[8]), 112);
      run_frame(5, 3, 100, 4'b1001, 0, 1'b0, "f5x3");

      // Degenerate W=2, H=8
      @(negedge clk);
      img_w = DW'(2);
      img_h = DW'(8);
      base  = AW'(33);
      ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("degen_done", 32'(done), 1);
      check("degen_valid", 32'(valid), 0);
      check("degen_busy", 32'(busy), 0);
      check("degen_state", 32'(dbg_state), 2);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("degen_post_done", 32'(done), 0);
         check("degen_post_valid", 32'(valid), 0);
         check("degen_post_busy", 32'(busy), 0);
      end

      // Abort with Clr after the 10th handshake, then restart
      fill_4x4();
      run_frame(4, 4, 0, 4'b1111, 10, 1'b0, "abort");
      fill_4x4();
      run_frame(4, 4, 0, 4'b1111, 0, 1'b0, "restart");

      // Start pulses in RUN and DONE ignored
      fill_model(4, 3, 7);
      run_frame(4, 3, 7, 4'b1111, 0, 1'b1, "poke");

      // Modulo-16 wrap on the 4-bit instance
      @(negedge clk);
      s_img_w = DW'(3);
      s_img_h = DW'(3);
      s_base  = SAW'(14);
      s_ready = 1'b1;
      s_start = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         s_start = 1'b0;
         check("wrap_valid", 32'(s_valid), 1);
         check("wrap_addr", 32'(s_addr), 32'(tbl_wrap[i]));
         check("wrap_last", 32'(s_win_last), 32'(i == 8));
      end
      @(negedge clk);
      check("wrap_done", 32'(s_done), 1);
      check("wrap_end_valid", 32'(s_valid), 0);
      @(negedge clk);
      check("wrap_post_done", 32'(s_done), 0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", err_cnt, chk_cnt);
      $fatal(1);
   end

endmodule
